// File: rtl/bitplane_serializer.sv
// ---------------------------------------------------------------------------
// bitplane_serializer
//
// Read side of the operand register file. A whole vector of VEC_LENGTH words
// (DATA_WIDTH bits each) is taken in one handshake and emitted to the
// bit-serial PE array one bit-plane per cycle, MSB (sign) plane first.
// An active/pending pair of vector registers lets the next vector load while
// the current one is still shifting out. With SKIP_ZERO = 1, planes whose bits
// are all zero are not emitted; an all-zero vector still emits one plane.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   in_data          VEC_LENGTH x DATA_WIDTH vector from the register file
//   in_valid         in_data is valid
//   in_ready         a vector can be accepted (pending slot is free)
//   out_plane        bit j = bit out_idx of word j of the active vector
//   out_idx          bit position carried by out_plane
//   out_first        first emitted plane of a vector
//   out_last         final emitted plane of a vector
//   out_valid        out_* fields are valid
//   out_ready        consumer takes the plane this cycle
//   busy             an active or pending vector is held
// ---------------------------------------------------------------------------
module bitplane_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int SKIP_ZERO  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data [VEC_LENGTH-1:0],
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [VEC_LENGTH-1:0]         out_plane,
    output logic [$clog2(DATA_WIDTH)-1:0] out_idx,
    output logic                          out_first,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int IW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] active_reg  [VEC_LENGTH-1:0];
    logic [DATA_WIDTH-1:0] pending_reg [VEC_LENGTH-1:0];
    logic                  active_valid_reg;
    logic                  pending_valid_reg;
    logic [IW-1:0]         counter_reg;
    logic                  first_reg;

    // Per-plane "any bit set" masks for each place a vector can come from.
    logic [DATA_WIDTH-1:0] nz_active;
    logic [DATA_WIDTH-1:0] nz_pending;
    logic [DATA_WIDTH-1:0] nz_in;
    logic [VEC_LENGTH-1:0] plane_bits;

    logic          next_found;
    logic [IW-1:0] next_idx;
    logic          last;
    logic [IW-1:0] step_idx;

    logic xfer;
    logic retire;
    logic accept;
    logic load_active;
    logic load_pending;
    logic promote;

    // Highest set plane of a mask, 0 when the mask is empty.
    function automatic logic [IW-1:0] top_plane(input logic [DATA_WIDTH-1:0] mask);
        logic [IW-1:0] top;
        top = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (mask[b]) begin
                top = IW'(b);
            end
        end
        return top;
    endfunction

    // Counter value for a freshly loaded vector.
    function automatic logic [IW-1:0] start_index(input logic [DATA_WIDTH-1:0] mask);
        logic [IW-1:0] idx;
        if (SKIP_ZERO != 0) begin
            idx = top_plane(mask);
        end else begin
            idx = IW'(DATA_WIDTH - 1);
        end
        return idx;
    endfunction

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_plane
            logic [VEC_LENGTH-1:0] col_active;
            logic [VEC_LENGTH-1:0] col_pending;
            logic [VEC_LENGTH-1:0] col_in;
            for (genvar gj = 0; gj < VEC_LENGTH; gj++) begin : g_word
                assign col_active[gj]  = active_reg[gj][gi];
                assign col_pending[gj] = pending_reg[gj][gi];
                assign col_in[gj]      = in_data[gj][gi];
            end
            assign nz_active[gi]  = |col_active;
            assign nz_pending[gi] = |col_pending;
            assign nz_in[gi]      = |col_in;
        end

        for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_out
            assign plane_bits[gi] = active_reg[gi][counter_reg];
        end
    endgenerate

    // Priority encoder: highest nonzero plane strictly below the counter.
    // Ascending scan so the highest qualifying plane is the one that sticks.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (nz_active[b] && (b < int'(counter_reg))) begin
                next_found = 1'b1;
                next_idx   = IW'(b);
            end
        end
    end

    always_comb begin
        last     = 1'b0;
        step_idx = '0;
        if (SKIP_ZERO != 0) begin
            last     = !next_found;
            step_idx = next_idx;
        end else begin
            last     = (counter_reg == '0);
            step_idx = counter_reg - 1'b1;
        end
    end

    assign xfer   = active_valid_reg && out_ready;
    assign retire = xfer && last;
    assign accept = in_valid && in_ready;

    // The pending slot only fills while the active vector keeps going; a
    // retiring active with an empty pending slot takes the new vector directly.
    assign load_active  = accept && (!active_valid_reg || (retire && !pending_valid_reg));
    assign load_pending = accept && active_valid_reg && !retire;
    assign promote      = retire && pending_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_valid_reg  <= 1'b0;
            pending_valid_reg <= 1'b0;
            counter_reg       <= IW'(DATA_WIDTH - 1);
            first_reg         <= 1'b0;
        end else begin
            if (promote) begin
                active_valid_reg <= 1'b1;
                counter_reg      <= start_index(nz_pending);
                first_reg        <= 1'b1;
            end else if (load_active) begin
                active_valid_reg <= 1'b1;
                counter_reg      <= start_index(nz_in);
                first_reg        <= 1'b1;
            end else if (retire) begin
                active_valid_reg <= 1'b0;
            end else if (xfer) begin
                counter_reg <= step_idx;
                first_reg   <= 1'b0;
            end

            // in_ready is low whenever pending is full, so a promote and a
            // pending load never coincide.
            if (load_pending) begin
                pending_valid_reg <= 1'b1;
            end else if (promote) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    // Vector storage needs no reset: every use is qualified by a valid flag.
    always_ff @(posedge clk) begin
        if (promote) begin
            active_reg <= pending_reg;
        end else if (load_active) begin
            active_reg <= in_data;
        end
        if (load_pending) begin
            pending_reg <= in_data;
        end
    end

    assign in_ready  = !pending_valid_reg;
    assign busy      = active_valid_reg || pending_valid_reg;
    assign out_valid = active_valid_reg;
    assign out_plane = active_valid_reg ? plane_bits : '0;
    assign out_idx   = active_valid_reg ? counter_reg : '0;
    assign out_first = active_valid_reg && first_reg;
    assign out_last  = active_valid_reg && last;

endmodule
